// File: rtl/sgd_rd_x_from_memory_if.sv
// Host-side control, DMA read command/data and x-memory write signals of the x loader.
// slave = the loader itself, master = the surrounding fabric (or a bench).
interface sgd_rd_x_from_memory_if #(
   parameter int ENGINE_NUM        = 8,
   parameter int NUM_BITS_PER_BANK = 64,
   parameter int X_ADDR_WIDTH      = 9
);
   localparam int BANK_W = NUM_BITS_PER_BANK * 32;

   logic                    load_start;
   logic [63:0]             addr_model;
   logic [31:0]             dimension;
   logic                    load_busy;
   logic                    load_done;
   logic                    load_error;
   logic                    x_data_rd_start;
   logic [63:0]             x_data_rd_addr;
   logic [31:0]             x_data_rd_length;
   logic [511:0]            x_data_in;
   logic                    x_data_in_valid;
   logic                    x_data_in_ready;
   logic [X_ADDR_WIDTH-1:0] x_mem_wr_addr;
   logic [ENGINE_NUM-1:0]   x_mem_wr_en;
   logic [BANK_W-1:0]       x_mem_wr_data;
   logic [31:0]             x_mem_beat_cnt;

   modport slave (
      input  load_start, addr_model, dimension, x_data_in, x_data_in_valid,
      output load_busy, load_done, load_error,
      output x_data_rd_start, x_data_rd_addr, x_data_rd_length, x_data_in_ready,
      output x_mem_wr_addr, x_mem_wr_en, x_mem_wr_data, x_mem_beat_cnt
   );

   modport master (
      output load_start, addr_model, dimension, x_data_in, x_data_in_valid,
      input  load_busy, load_done, load_error,
      input  x_data_rd_start, x_data_rd_addr, x_data_rd_length, x_data_in_ready,
      input  x_mem_wr_addr, x_mem_wr_en, x_mem_wr_data, x_mem_beat_cnt
   );
endinterface

// File: rtl/sgd_rd_x_from_memory.sv
// Loads model vector x from host memory into the per-engine x memories (row/engine/quarter order).
// Optional build macro SGD_RD_X_ZERO_PAD_EN: features at or beyond dimension are written as zero.
module sgd_rd_x_from_memory #(
   parameter int ENGINE_NUM        = 8,
   parameter int NUM_BITS_PER_BANK = 64,
   parameter int X_ADDR_WIDTH      = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   sgd_rd_x_from_memory_if.slave bus
);
   localparam int BEAT_W        = 512;
   localparam int BANK_W        = NUM_BITS_PER_BANK * 32;
   localparam int QUARTERS      = BANK_W / BEAT_W;
   localparam int FEAT_PER_BEAT = BEAT_W / 32;
   localparam int FEAT_PER_ROW  = ENGINE_NUM * NUM_BITS_PER_BANK;
   localparam int BYTES_PER_ROW = ENGINE_NUM * QUARTERS * (BEAT_W / 8);
   localparam int ENG_W         = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
   localparam int Q_W           = (QUARTERS > 1) ? $clog2(QUARTERS) : 1;

   localparam logic [ENG_W-1:0] ENG_LAST = ENG_W'(ENGINE_NUM - 1);
   localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUARTERS - 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t state, state_nx;

   logic [63:0]                    addr_r;
   logic [31:0]                    dim_r;
   logic [31:0]                    rows_r;
   logic [31:0]                    row_idx;
   logic [ENG_W-1:0]               eng_idx;
   logic [Q_W-1:0]                 q_idx;
   logic [(QUARTERS-1)*BEAT_W-1:0] pack_buf;

   logic        beat_ok;
   logic        last_beat;
   logic [32:0] rows_sum;
   logic [31:0] rows_calc;
   logic [31:0] len_calc;
   logic [BEAT_W-1:0] beat_data;

   assign rows_sum  = {1'b0, dim_r} + 33'(FEAT_PER_ROW - 1);
   assign rows_calc = 32'(rows_sum / 33'(FEAT_PER_ROW));
   assign len_calc  = rows_calc * 32'(BYTES_PER_ROW);

`ifdef SGD_RD_X_ZERO_PAD_EN
   // Global feature index of lane 0 in the beat currently on the bus.
   logic [63:0] beat_base;
   assign beat_base = 64'(row_idx) * 64'(FEAT_PER_ROW)
                    + 64'(eng_idx) * 64'(NUM_BITS_PER_BANK)
                    + 64'(q_idx)   * 64'(FEAT_PER_BEAT);
   for (genvar l = 0; l < FEAT_PER_BEAT; l++) begin : g_pad
      assign beat_data[l*32 +: 32] = ((beat_base + 64'(l)) >= {32'd0, dim_r}) ?
                                     32'd0 : bus.x_data_in[l*32 +: 32];
   end
`else
   assign beat_data = bus.x_data_in;
`endif

   assign bus.x_data_in_ready = (state == DATA);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      beat_ok   = 1'b0;
      last_beat = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load_start) state_nx = (bus.dimension == 32'd0) ? DONE : CMD;
         end
         CMD:  state_nx = DATA;
         DATA: begin
            beat_ok   = bus.x_data_in_valid;
            last_beat = beat_ok && (q_idx == Q_LAST) && (eng_idx == ENG_LAST) &&
                        (row_idx == rows_r - 32'd1);
            if (last_beat) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r               <= '0;
         dim_r                <= '0;
         rows_r               <= '0;
         row_idx              <= '0;
         eng_idx              <= '0;
         q_idx                <= '0;
         pack_buf             <= '0;
         bus.load_busy        <= 1'b0;
         bus.load_done        <= 1'b0;
         bus.load_error       <= 1'b0;
         bus.x_data_rd_start  <= 1'b0;
         bus.x_data_rd_addr   <= '0;
         bus.x_data_rd_length <= '0;
         bus.x_mem_wr_addr    <= '0;
         bus.x_mem_wr_en      <= '0;
         bus.x_mem_wr_data    <= '0;
         bus.x_mem_beat_cnt   <= '0;
      end else begin
         bus.x_data_rd_start <= 1'b0;
         bus.load_done       <= 1'b0;
         bus.x_mem_wr_en     <= '0;
         case (state)
            IDLE: begin
               if (bus.load_start) begin
                  addr_r             <= bus.addr_model;
                  dim_r              <= bus.dimension;
                  bus.load_error     <= (bus.dimension == 32'd0);
                  bus.load_busy      <= 1'b1;
                  bus.x_mem_beat_cnt <= '0;
                  row_idx            <= '0;
                  eng_idx            <= '0;
                  q_idx              <= '0;
               end
            end
            CMD: begin
               rows_r               <= rows_calc;
               bus.x_data_rd_start  <= 1'b1;
               bus.x_data_rd_addr   <= addr_r;
               bus.x_data_rd_length <= len_calc;
            end
            DATA: begin
               if (beat_ok) begin
                  if (bus.x_mem_beat_cnt != '1) bus.x_mem_beat_cnt <= bus.x_mem_beat_cnt + 32'd1;
                  if (q_idx == Q_LAST) begin
                     // Last quarter completes the bank word; it bypasses the pack buffer.
                     bus.x_mem_wr_en   <= ENGINE_NUM'(1) << eng_idx;
                     bus.x_mem_wr_data <= {beat_data, pack_buf};
                     bus.x_mem_wr_addr <= row_idx[X_ADDR_WIDTH-1:0];
                     q_idx             <= '0;
                     if (eng_idx == ENG_LAST) begin
                        eng_idx <= '0;
                        row_idx <= row_idx + 32'd1;
                     end else begin
                        eng_idx <= eng_idx + ENG_W'(1);
                     end
                  end else begin
                     for (int k = 0; k < QUARTERS - 1; k++)
                        if (q_idx == Q_W'(k)) pack_buf[k*BEAT_W +: BEAT_W] <= beat_data;
                     q_idx <= q_idx + Q_W'(1);
                  end
               end
            end
            DONE: begin
               bus.load_done <= 1'b1;
               bus.load_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/sgd_rd_x_from_memory.md
Name: sgd_rd_x_from_memory

Overview:
Loads the model vector x from host memory into the distributed on-chip x memories before training, or on reload between runs. It is the inbound counterpart of the x write-back path. The block issues one DMA read command covering the whole model, accepts 512-bit beats, and packs four beats into one 2048-bit bank word per engine. It writes each bank word into the engine's x memory row in the same row/engine/quarter order that write-back uses.

Parameters:
ENGINE_NUM, 8, number of engines / x memory banks
NUM_BITS_PER_BANK, 64, features per engine per row; bank word width = NUM_BITS_PER_BANK*32 = 2048
X_ADDR_WIDTH, 9, x memory row address width (matches DIS_X_BIT_DEPTH)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
load_start  in  1  one-cycle pulse that begins a load
addr_model  in  64  host byte address of x; sampled on load_start
dimension  in  32  number of features; sampled on load_start
load_busy  out  1  high from accepted load_start until done
load_done  out  1  one-cycle pulse when the load completes
load_error  out  1  sticky until the next accepted load_start; set when dimension==0
x_data_rd_start  out  1  one-cycle read command pulse
x_data_rd_addr  out  64  read address, valid with rd_start
x_data_rd_length  out  32  read length in bytes, valid with rd_start
x_data_in  in  512  inbound data beat
x_data_in_valid  in  1  beat valid
x_data_in_ready  out  1  block accepts a beat
x_mem_wr_addr  out  X_ADDR_WIDTH  x memory row address
x_mem_wr_en  out  ENGINE_NUM  one-hot per-engine write strobe
x_mem_wr_data  out  2048  bank word, shared by all engines
x_mem_beat_cnt  out  32  debug: beats accepted since the last load_start

Behaviour:
- Reset: all outputs are 0; state is IDLE; all counters are 0.
- ROWS = ceil(dimension/(ENGINE_NUM*NUM_BITS_PER_BANK)) = ceil(dimension/512) at defaults. This value is registered in CMD.
- Read length = ROWS*ENGINE_NUM*4*64 bytes, i.e. ROWS*2048 at defaults. Total beats = ROWS*ENGINE_NUM*4.
- FSM:
  - IDLE: when load_start is high, latch the inputs, clear load_error and x_mem_beat_cnt, set load_busy. If dimension==0, go to DONE and set load_error. Otherwise go to CMD.
  - CMD: one cycle. Compute ROWS and length. Next cycle x_data_rd_start=1 with addr_model and the length; go to DATA.
  - DATA: x_data_in_ready=1. A beat is accepted when valid&ready.
    - Beat with inner index q (0..3) goes into word bits [512q+511:512q].
    - On the 4th beat (q=3): next cycle drive x_mem_wr_en[engine_index]=1 for exactly one cycle, with the full word and x_mem_wr_addr=row_index. The write latency is therefore 1 cycle after the 4th beat.
    - Then engine_index increments. When it wraps past ENGINE_NUM-1, it returns to 0 and row_index increments.
    - After the 4th beat of engine ENGINE_NUM-1 in row ROWS-1, go to DONE. ready drops the cycle after that last beat.
  - DONE: the final write has already issued. Pulse load_done for one cycle, clear load_busy, go to IDLE.
- Order: row-major; within a row engines 0..ENGINE_NUM-1; within an engine quarters 0..3.
- Gaps in valid stall the pack counters; no partial word is ever written.
- load_start while busy is ignored. Beats arriving in IDLE/CMD/DONE see ready=0 and are not consumed.
- Row counter: rows at or beyond 2^X_ADDR_WIDTH are out of range. x_mem_wr_addr is truncated to X_ADDR_WIDTH bits; the caller guarantees ROWS <= 2^X_ADDR_WIDTH.
- Reset mid-operation aborts immediately: no further write, no done pulse, return to the reset state.
- x_mem_beat_cnt increments on every accepted beat and saturates at 2^32-1.

Optional Feature:
SGD_RD_X_ZERO_PAD_EN.
- Defined: every 32-bit feature whose global index ≥ dimension is written as 0. Global index = row*512 + engine*64 + q*16 + lane, where lane = 0..15 within a beat.
- Not defined: data is written exactly as received.
- Cycle timing is identical in both builds.

Test Plan:
- dimension=512, addr=0x1000 -> one rd_start with addr 0x1000 and length 2048. 32 beats with ready held. 8 writes at row 0, engines 0..7, each 1 cycle after its 4th beat. load_done pulses once; beat_cnt=32.
- dimension=1000 with valid toggling every other cycle -> length 4096, 64 beats. Writes to rows 0 and 1; each word equals the concatenation of 4 beats with beat0 in the LSBs. There are no writes during gaps.
- dimension=0 -> no rd_start and no writes. load_error=1; load_done pulses 2 cycles after load_start.
- Reset asserted after 10 beats -> all outputs 0 immediately; no write and no done. A new load then completes normally.
- load_start pulsed again mid-load -> ignored; the original load completes with the original count.
- With SGD_RD_X_ZERO_PAD_EN, dimension=520, all-ones beats -> row0 fully ones. Row1 engine0 quarter0 lanes 0..7 are ones, lanes 8..15 are zero, and everything after that is zero. Without the macro, all words are ones.
